bin2bcd_seq: RTL
================

# bin2bcd_seq

Parametrised, iterative binary-to-BCD converter using shift-and-add-3, with valid/ready handshakes on both sides. It generalises the fixed 16-bit, table-lookup converter used in the ADC display path to any input width and digit count, optionally in signed (two's complement) mode, and flags overflow. It sits between measurement or ADC sample logic and the 7-segment or LCD digit drivers.

## Interface
- BIN_W, 16: binary input width; legal range 2..32.
- DIGITS, 5: number of BCD output digits; legal range 1..10.
- SIGNED, 0: 1 = `bin` is two's complement; the magnitude is converted and the sign is reported on `neg`.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  `bin` is valid.
- in_ready  out  1  converter can accept a new value.
- bin  in  BIN_W  value to convert.
- out_valid  out  1  result is valid; held until consumed.
- out_ready  in  1  downstream accepts the result.
- bcd  out  4*DIGITS  packed BCD result; digit 0 is in bits [3:0].
- neg  out  1  input was negative (SIGNED=1 only; otherwise constant 0).
- overflow  out  1  the magnitude exceeded 10^DIGITS−1; `bcd` then holds the low DIGITS digits of the true value.

## Operation
- FSM states and transitions:
  - IDLE → SHIFT on accept.
  - SHIFT → DONE after BIN_W iterations.
  - DONE → IDLE on `out_valid && out_ready && !in_valid`.
  - DONE → SHIFT on `out_valid && out_ready && in_valid`: back-to-back accept.
- Handshake signals:
  - `in_ready = (state==IDLE) || (state==DONE && out_ready)`.
  - Accept occurs when `in_valid && in_ready`.
  - `out_valid = (state==DONE)`.
- On accept:
  - Latch the magnitude into a BIN_W shift register.
  - For SIGNED=1 with `bin[BIN_W-1]=1`, the magnitude is `-bin` taken as BIN_W-bit unsigned, so −2^(BIN_W−1) maps to 2^(BIN_W−1). Set `neg`.
  - Clear the BCD accumulator and the overflow flag.
  - Load iteration counter = BIN_W−1.
- Each SHIFT cycle:
  - Every accumulator digit ≥5 gets +3.
  - Then {accumulator, shift register} shifts left by 1, so the MSB of the shift register enters digit 0 bit 0.
  - A 1 shifted out of the top digit bit 3 sets `overflow`, which is sticky for that conversion.
  - The counter decrements. Leave SHIFT when the counter is 0.
- The counter width is $clog2(BIN_W).
- `bcd`, `neg` and `overflow` are registered outputs. They are stable throughout DONE and while waiting for `out_ready`. Input changes do not affect them outside an accept.
- In IDLE, outputs keep the last result and are not revalidated.

## Timing
- Reset values:
  - state = IDLE
  - in_ready = 1
  - out_valid = 0
  - bcd = 0
  - neg = 0
  - overflow = 0
  - counter = 0
- Latency: accept at edge E. `out_valid` rises after edge E+BIN_W. The result is sampled by downstream on the first edge with `out_ready=1`.
- Throughput: one result per BIN_W+1 cycles with `out_ready` tied high. Back-to-back accept in DONE removes the idle cycle.
- `in_ready` depends combinationally on `out_ready` in DONE. This is the only combinational input-to-output path.
- Reset mid-conversion aborts immediately, with no output. The first accept after reset release converts normally.
- Inputs arriving during SHIFT are ignored (`in_ready=0`). The upstream holds `in_valid`.

## Structure
- Package `bcd_pkg`:
  - state enum {IDLE, SHIFT, DONE}.
  - Constant `BCD_ADJ_THRESH=4'd5`.
  - Function `bcd_add3(digit)`, used by the sub-module.
- Sub-module `bcd_digit_adj`: a single combinational digit stage (≥5 → +3). It is instantiated DIGITS times by a generate loop. It is reused by future BCD counters.
- Top module: FSM, iteration counter, shift register, accumulator, output registers.

## Test plan
- Defaults: `bin=16'hFFFF` → after 16 cycles `bcd=20'h65535`, `overflow=0`, `neg=0`; `bin=0` → `bcd=20'h00000`.
- DIGITS=4, `bin=16'd12345` → `overflow=1`, `bcd=16'h2345`; `bin=16'd9999` → `overflow=0`, `bcd=16'h9999`.
- SIGNED=1, `bin=16'h8000` → `neg=1`, `bcd=20'h32768`; `bin=16'hFFFF` → `neg=1`, `bcd=20'h00001`; `bin=16'h7FFF` → `neg=0`, `bcd=20'h32767`.
- Backpressure: `out_ready=0` for 10 cycles after `out_valid` → outputs stable, `in_ready=0`. Then `out_ready=1` with `in_valid=1`, `bin=16'd4096` → back-to-back accept; next result `bcd=20'h04096` after 16 more cycles.
- Reset: assert `rst` at iteration 7 of converting 16'd1234 → same cycle: `out_valid=0`, `bcd=0`, `in_ready=1`. The next conversion of 16'd42 gives `bcd=20'h00042`.
- Random: 10k random values for BIN_W∈{8,12,16,24}, DIGITS∈{3,5,8}, SIGNED∈{0,1} against a scoreboard, checking latency = BIN_W exactly.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the BCD conversion and counter blocks.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;

  // Double-dabble correction: a digit that will reach 10+ after doubling gets +3 first.
  function automatic logic [3:0] bcd_add3(input logic [3:0] digit);
    return (digit >= BCD_ADJ_THRESH) ? digit + 4'd3 : digit;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Valid/ready bundle between the binary source, the converter and the digit drivers.
interface bin2bcd_seq_if #(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [BIN_W-1:0]      bin;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   bcd;
  logic                  neg;
  logic                  overflow;

  modport master (
    output in_valid, bin, out_ready,
    input  in_ready, out_valid, bcd, neg, overflow
  );

  modport slave (
    input  in_valid, bin, out_ready,
    output in_ready, out_valid, bcd, neg, overflow
  );
endinterface

// File: rtl/bcd_digit_adj.sv
// One combinational shift-and-add-3 digit stage.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);
  assign dout = bcd_add3(din);
endmodule

// File: rtl/bin2bcd_seq.sv
// Iterative binary-to-BCD converter (shift-and-add-3), one bit per clock,
// optional two's complement input and sticky overflow for too few digits.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 16,
  parameter int DIGITS = 5,
  parameter int SIGNED = 0
) (
  input  logic          clk,
  input  logic          rst,
  bin2bcd_seq_if.slave  bus
);
  localparam int ACC_W = 4 * DIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic [BIN_W-1:0]  sr_reg;
  logic [ACC_W-1:0]  acc_reg, acc_adj, acc_next;
  logic              ovf_reg, ovf_next, neg_reg;
  logic [ACC_W-1:0]  bcd_reg;
  logic              bcd_ovf_reg, bcd_neg_reg;
  logic              in_ready_c, accept, last_iter, is_neg;
  logic [BIN_W-1:0]  mag;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      bcd_digit_adj u_adj (
        .din  (acc_reg[4*gi +: 4]),
        .dout (acc_adj[4*gi +: 4])
      );
    end
  endgenerate

  // The most negative input maps to 2^(BIN_W-1), which still fits unsigned.
  assign is_neg    = (SIGNED != 0) && bus.bin[BIN_W-1];
  assign mag       = is_neg ? BIN_W'(-bus.bin) : bus.bin;
  assign last_iter = (cnt_reg == '0);
  assign acc_next  = {acc_adj[ACC_W-2:0], sr_reg[BIN_W-1]};
  assign ovf_next  = ovf_reg | acc_adj[ACC_W-1];
  assign accept    = bus.in_valid && in_ready_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    in_ready_c = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) state_next = SHIFT;
      end
      SHIFT: begin
        if (last_iter) state_next = DONE;
      end
      DONE: begin
        in_ready_c = bus.out_ready;
        if (bus.out_ready) state_next = bus.in_valid ? SHIFT : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg     <= '0;
      sr_reg      <= '0;
      acc_reg     <= '0;
      ovf_reg     <= 1'b0;
      neg_reg     <= 1'b0;
      bcd_reg     <= '0;
      bcd_ovf_reg <= 1'b0;
      bcd_neg_reg <= 1'b0;
    end else if (accept) begin
      sr_reg  <= mag;
      acc_reg <= '0;
      ovf_reg <= 1'b0;
      neg_reg <= is_neg;
      cnt_reg <= CNT_W'(BIN_W - 1);
    end else if (state_reg == SHIFT) begin
      sr_reg  <= {sr_reg[BIN_W-2:0], 1'b0};
      acc_reg <= acc_next;
      ovf_reg <= ovf_next;
      if (!last_iter) cnt_reg <= cnt_reg - 1'b1;
      // Results are published only when complete so bcd never shows partial sums.
      if (last_iter) begin
        bcd_reg     <= acc_next;
        bcd_ovf_reg <= ovf_next;
        bcd_neg_reg <= neg_reg;
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = (state_reg == DONE);
  assign bus.bcd       = bcd_reg;
  assign bus.neg       = bcd_neg_reg;
  assign bus.overflow  = bcd_ovf_reg;

endmodule
